// File: rtl/mux_unstriping_pkg.sv
// Shared definitions for the two-lane unstriping stage: default word width,
// lane indices and FIFO pointer sizing.
package mux_unstriping_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  // Pointer width for a FIFO of the given depth; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mux_unstriping_lane_fifo.sv
// Per-lane synchronous FIFO with asynchronous active-low reset. The head word
// is read combinationally; push into full and pop from empty are ignored.
module lane_fifo
  import mux_unstriping_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic              clk_f,
  input  logic              reset_L,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage is not reset: only pointers and count define what is valid.
  always_ff @(posedge clk_f) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mux_unstriping.sv
// Merges two lane FIFOs back into one stream by strict alternation starting
// at lane 0, restoring the word order produced by the striping stage.
module mux_unstriping
  import mux_unstriping_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk_f,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_in0,
  input  logic              valid_in0,
  output logic              ready_out0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic              valid_in1,
  output logic              ready_out1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              lane_sel
);

  localparam int CNT_W = ptr_w(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Handshake: a word moves on any edge where valid and ready are both high;
  // valid never waits on ready, and a ready output depends only on registered
  // state (plus reset), so no combinational path runs from valid to ready.

  logic [DATA_W-1:0] head0, head1;
  logic              full0, full1;
  logic              empty0, empty1;
  logic [CNT_W-1:0]  count0, count1;
  logic              push0, push1;
  logic              pop0, pop1;
  logic              unused_full;

  assign ready_out0  = reset_L && (count0 != FULL_CNT);
  assign ready_out1  = reset_L && (count1 != FULL_CNT);
  assign push0       = valid_in0 && ready_out0;
  assign push1       = valid_in1 && ready_out1;
  assign unused_full = full0 ^ full1;

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk_f   (clk_f),
    .reset_L (reset_L),
    .push    (push0),
    .pop     (pop0),
    .din     (data_in0),
    .dout    (head0),
    .full    (full0),
    .empty   (empty0),
    .count   (count0)
  );

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk_f   (clk_f),
    .reset_L (reset_L),
    .push    (push1),
    .pop     (pop1),
    .din     (data_in1),
    .dout    (head1),
    .full    (full1),
    .empty   (empty1),
    .count   (count1)
  );

  logic              may_load;
  logic              sel_empty;
  logic [DATA_W-1:0] sel_head;
  logic [DATA_W-1:0] data_nxt;
  logic              valid_nxt;
  logic              lane_sel_nxt;

  // Only the selected lane is ever consulted; that is what preserves order.
  always_comb begin
    may_load     = !valid_out || ready_in;
    sel_empty    = (lane_sel == LANE0) ? empty0 : empty1;
    sel_head     = (lane_sel == LANE0) ? head0 : head1;
    data_nxt     = data_out;
    valid_nxt    = valid_out;
    lane_sel_nxt = lane_sel;
    pop0         = 1'b0;
    pop1         = 1'b0;
    if (may_load) begin
      if (!sel_empty) begin
        data_nxt     = sel_head;
        valid_nxt    = 1'b1;
        lane_sel_nxt = ~lane_sel;
        pop0         = (lane_sel == LANE0);
        pop1         = (lane_sel == LANE1);
      end else if (ready_in) begin
        valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      lane_sel  <= LANE0;
    end else begin
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
      lane_sel  <= lane_sel_nxt;
    end
  end

endmodule
